uart_receiver: RTL and testbench

//  UART RX: recovers 8N1 frames (8E1 with parity option) from an async serial line, LSB first.

---
 rtl/uart_receiver_if.sv | 34 +++
 rtl/uart_receiver.sv | 167 ++++++++++++++++
 tb/tb_uart_receiver.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/uart_receiver_if.sv
// Fabric-side bundle of the UART receiver: serial line in, byte/status out.
// The parity_err signal exists only when UART_RX_PARITY_EN is defined.
interface uart_receiver_if;
  logic       rx;
  logic [7:0] data_out;
  logic       valid;
  logic       busy;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  modport slave (
    input  rx,
    output data_out,
    output valid,
    output busy,
    output frame_err
`ifdef UART_RX_PARITY_EN
    , output parity_err
`endif
  );

  modport master (
    output rx,
    input  data_out,
    input  valid,
    input  busy,
    input  frame_err
`ifdef UART_RX_PARITY_EN
    , input  parity_err
`endif
  );
endinterface

// File: rtl/uart_receiver.sv
// UART receiver: 8N1 frames, LSB first, mid-bit sampling off a 2-flop synchronized line.
// Define UART_RX_PARITY_EN for 8E1 frames with an extra PARITY state and parity_err output.
module uart_receiver #(
  parameter int BAUD_RATE    = 9_600,
  parameter int SYS_CLK_FREQ = 48_000_000
) (
  input logic            clk,
  input logic            reset,
  uart_receiver_if.slave bus
);
  localparam int BIT_PERIOD  = SYS_CLK_FREQ / BAUD_RATE;
  localparam int HALF_PERIOD = BIT_PERIOD / 2;
  localparam int TW          = $clog2(BIT_PERIOD);
  localparam logic [TW-1:0] T_BIT  = TW'(BIT_PERIOD - 1);
  localparam logic [TW-1:0] T_HALF = TW'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          ferr_q, ferr_d;
  logic          rx_meta_q, rx_s_q;
  logic          tick;
`ifdef UART_RX_PARITY_EN
  logic          par_bit_q, par_bit_d;
  logic          perr_q, perr_d;
`endif

  assign tick = (timer_q == '0);

  // Line synchronizer resets to the idle-high level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= par_bit_d;
      perr_q    <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    ferr_d    = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_bit_d = par_bit_q;
    perr_d    = perr_q;
`endif
    if (state_q != S_IDLE && state_q != S_WAIT_IDLE && !tick)
      timer_d = timer_q - 1'b1;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (!rx_s_q) begin
          busy_d  = 1'b1;
          timer_d = T_HALF;
          state_d = S_START;
        end
      end
      S_START: if (tick) begin
        if (!rx_s_q) begin
          timer_d   = T_BIT;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_DATA: if (tick) begin
        shift_d[bit_idx_q] = rx_s_q;
        timer_d            = T_BIT;
        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end else begin
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (tick) begin
        par_bit_d = rx_s_q;
        timer_d   = T_BIT;
        state_d   = S_STOP;
      end
`endif
      S_STOP: if (tick) begin
        data_d  = shift_q;
        valid_d = 1'b1;
        ferr_d  = ~rx_s_q;
`ifdef UART_RX_PARITY_EN
        perr_d  = (^shift_q) ^ par_bit_q;
`endif
        // A low stop bit means break or framing fault: wait for the line to recover.
        if (rx_s_q) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: if (rx_s_q) begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.data_out  = data_q;
  assign bus.valid     = valid_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`endif
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit; a scoreboard queue holds the
// expected byte/status for every frame sent and a negedge monitor checks each valid pulse.
module tb_uart_receiver;
  localparam int BIT = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   errs    = 0;

  uart_receiver_if bus();

  uart_receiver #(.BAUD_RATE(10_000), .SYS_CLK_FREQ(160_000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Every valid pulse must match the oldest outstanding frame.
  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("data_out", {24'd0, bus.data_out}, {24'd0, mon_e.d});
        chk("frame_err", {31'd0, bus.frame_err}, {31'd0, mon_e.fe});
`ifdef UART_RX_PARITY_EN
        chk("parity_err", {31'd0, bus.parity_err}, {31'd0, mon_e.pe});
`endif
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    bus.rx = b;
    tick(BIT);
  endtask

  // Serializer standing in for the matching transmitter.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    exp_t e;
    e.d  = d;
    e.fe = ~stop_b;
    e.pe = (^d) ^ par_b;
    sb.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_b);
`endif
    drive_bit(stop_b);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && sb.size() != 0; i++) tick(1);
    chk({tag, "_drained"}, sb.size(), 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    bus.rx = 1'b1;
    reset  = 1'b1;
    tick(5);
    reset = 1'b0;
    tick(1);
    chk("rst_data_out", {24'd0, bus.data_out}, 32'd0);
    chk("rst_valid", {31'd0, bus.valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
`ifdef UART_RX_PARITY_EN
    chk("rst_parity_err", {31'd0, bus.parity_err}, 32'd0);
`endif
    tick(500);
    chk("idle_busy", {31'd0, bus.busy}, 32'd0);

    send_frame(8'hA5, 1'b1, ^8'hA5);
    drain("a5");
    chk("a5_busy_after", {31'd0, bus.busy}, 32'd0);
    chk("a5_data_held", {24'd0, bus.data_out}, 32'h0000_00A5);

    bus.rx = 1'b0;
    tick(4);
    chk("glitch_busy", {31'd0, bus.busy}, 32'd1);
    bus.rx = 1'b1;
    tick(20);
    chk("glitch_idle", {31'd0, bus.busy}, 32'd0);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    drain("3c");
    chk("3c_data_held", {24'd0, bus.data_out}, 32'h0000_003C);

    send_frame(8'h00, 1'b0, 1'b0);
    tick(40);
    drain("break");
    chk("break_busy", {31'd0, bus.busy}, 32'd1);
    chk("break_ferr_held", {31'd0, bus.frame_err}, 32'd1);
    bus.rx = 1'b1;
    tick(5);
    chk("break_recover", {31'd0, bus.busy}, 32'd0);
    tick(BIT);
    send_frame(8'h55, 1'b1, ^8'h55);
    drain("55");
    chk("55_ferr_clear", {31'd0, bus.frame_err}, 32'd0);

    send_frame(8'h01, 1'b1, ^8'h01);
    send_frame(8'hFF, 1'b1, ^8'hFF);
    send_frame(8'h80, 1'b1, ^8'h80);
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, ^b);
    end
    drain("b2b");
    chk("b2b_last", {24'd0, bus.data_out}, {24'd0, b});

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    send_frame(8'h07, 1'b1, 1'b0);
    drain("parity");
    chk("parity_err_held", {31'd0, bus.parity_err}, 32'd1);
`endif

    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    chk("mid_frame_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    tick(2);
    bus.rx = 1'b1;
    reset  = 1'b0;
    tick(1);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_data_out", {24'd0, bus.data_out}, 32'd0);
    tick(300);
    chk("abort_quiet", {31'd0, bus.busy}, 32'd0);
    chk("abort_no_pending", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
